fd_pipe_reg: RTL and testbench
==============================

Name: fd_pipe_reg

Overview:
- IF/ID pipeline register between the fetch stage and the decode stage of the 5-stage MIPS pipeline.
- Captures the fetched instruction, pc4 and the fetch address-error flag every cycle.
- Supports stall (hold) and flush (bubble).
- Derives and presents to decode: the instruction PC, a 5-bit exception code, the branch-delay-slot (BD) flag and a valid bit. Downstream CP0 logic uses these for precise exceptions.

Parameters:
- RESET_PC, 32'h0000_3000, PC value presented on pc_d while the register holds a bubble after reset.
- EXC_ADEL, 5'd4, exception code latched for a misaligned or out-of-range fetch.
- STALL_CNT_W, 8, width of the saturating stall-cycle counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- clr  input  1  synchronous reset, active-low: clr==0 at a rising edge resets all state.
- en  input  1  1 = load new F-stage values; 0 = stall, hold contents.
- flush  input  1  1 = load a bubble (exception, interrupt or eret redirect).
- IFUOUT_f  input  32  instruction fetched this cycle.
- pc4_f  input  32  fetch PC + 4.
- WAPC_f  input  1  fetch address error (PC[1:0]!=0 or PC outside 0x3000..0x4ffc).
- IR_d  output  32  instruction in D.
- pc4_d  output  32  latched pc4.
- pc_d  output  32  pc4_d - 4 (combinational from the register).
- exc_d  output  5  0 = none, EXC_ADEL = fetch address error.
- bd_d  output  1  instruction in D sits in a branch/jump delay slot.
- valid_d  output  1  0 = bubble.
- stall_cnt  output  STALL_CNT_W  saturating count of cycles with en==0 while valid_d==1.

Behaviour:
- Update priority at each rising edge: clr==0 > flush==1 > en==0 > load.
- Reset (clr==0):
  - IR_d=0, pc4_d=RESET_PC+4, exc_d=0, bd_d=0, valid_d=0, stall_cnt=0.
  - The same values result if clr is asserted in the middle of a stall or a flush.
- Flush:
  - IR_d=0, exc_d=0, bd_d=0, valid_d=0.
  - pc4_d = pc4_f, so CP0 sees the redirect target.
  - stall_cnt holds its value.
  - Flush overrides a simultaneous en==0.
- Stall (en==0, flush==0): every output holds its value. stall_cnt increments by 1 if valid_d==1 and saturates at all-ones; it never wraps.
- Load (en==1, flush==0):
  - pc4_d = pc4_f and valid_d = 1.
  - If WAPC_f==1: IR_d = 0 (nop, so decode never sees a garbage opcode) and exc_d = EXC_ADEL.
  - If WAPC_f==0: IR_d = IFUOUT_f and exc_d = 0.
  - bd_d = 1 if the instruction held in IR_d before the edge is a branch or jump and valid_d was 1; otherwise bd_d = 0.
- Branch/jump set, decoded on IR_d:
  - op = 000100, 000101, 000110, 000111, 000001 (REGIMM), 000010, 000011.
  - op = 000000 with funct = 001000 (jr) or 001001 (jalr).
- bd_d is computed from the register contents, never from IFUOUT_f. An address-error slot behind a branch therefore still gets bd_d=1.
- Latency: 1 cycle from F to D. pc_d, and the branch decode that feeds bd_d, are combinational from registered state.
- pc4 arithmetic is 32-bit modulo 2^32. pc_d for pc4_d = 0 is 32'hFFFF_FFFC.

Test Plan:
- Reset: hold clr=0 for 2 cycles with arbitrary inputs -> IR_d=0, valid_d=0, pc_d=32'h3000, stall_cnt=0. Release clr, load IFUOUT_f=32'h2408_0005, pc4_f=32'h3004 -> next cycle IR_d=32'h2408_0005, pc_d=32'h3000, valid_d=1, exc_d=0.
- Delay slot: load beq (32'h1109_0003) then addu (32'h0109_5021) -> addu cycle shows bd_d=1. Load another addu next -> bd_d=0. Repeat the sequence with jr 32'h03E0_0008 -> bd_d=1 on its slot.
- Address error: WAPC_f=1, IFUOUT_f=32'hFFFF_FFFF, pc4_f=32'h3002 -> IR_d=0, exc_d=4, pc_d=32'h2FFE, valid_d=1.
- Stall: hold en=0 for 3 cycles with changing inputs -> all outputs frozen, stall_cnt goes 0->3. With STALL_CNT_W=2, 5 stall cycles -> stall_cnt saturates at 3.
- Flush vs stall: flush=1 and en=0 together, pc4_f=32'h4184 -> valid_d=0, IR_d=0, bd_d=0, pc4_d=32'h4184, stall_cnt unchanged.
- Reset mid-stall: en=0 with stall_cnt=2, then clr=0 for 1 cycle -> all outputs at reset values, stall_cnt=0.

Source files
------------

// File: rtl/fd_pipe_reg.sv
// IF/ID pipeline register for the 5-stage MIPS pipeline.
// Holds the fetched instruction, pc4 and the fetch address-error result, and
// derives the PC, exception code, delay-slot flag and valid bit for decode.
//
// Control semantics (evaluated at each rising edge, highest priority first):
//   clr==0   -> reset to a bubble at RESET_PC, stall counter cleared
//   flush==1 -> bubble, but pc4_d takes pc4_f so CP0 sees the redirect target
//   en==0    -> stall: all contents held, stall counter counts if valid_d
//   en==1    -> load the F-stage values
module fd_pipe_reg #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter logic [4:0]  EXC_ADEL    = 5'd4,
  parameter int          STALL_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   en,
  input  logic                   flush,
  input  logic [31:0]            IFUOUT_f,
  input  logic [31:0]            pc4_f,
  input  logic                   WAPC_f,
  output logic [31:0]            IR_d,
  output logic [31:0]            pc4_d,
  output logic [31:0]            pc_d,
  output logic [4:0]             exc_d,
  output logic                   bd_d,
  output logic                   valid_d,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam logic [31:0]            RESET_PC4 = RESET_PC + 32'd4;
  localparam logic [STALL_CNT_W-1:0] CNT_ONE   = 1;
  localparam logic [STALL_CNT_W-1:0] CNT_MAX   = '1;

  logic [5:0] op;
  logic [5:0] funct;
  logic       ir_is_branch;

  assign op    = IR_d[31:26];
  assign funct = IR_d[5:0];

  // Instruction PC is recovered from the latched pc4 (modulo 2^32).
  assign pc_d = pc4_d - 32'd4;

  // Branch/jump decode of the instruction currently held in D; feeds bd_d of
  // the next instruction loaded behind it.
  always_comb begin
    ir_is_branch = 1'b0;
    case (op)
      6'b000100, 6'b000101, 6'b000110, 6'b000111,
      6'b000001, 6'b000010, 6'b000011: ir_is_branch = 1'b1;
      6'b000000: ir_is_branch = (funct == 6'b001000) || (funct == 6'b001001);
      default:   ir_is_branch = 1'b0;
    endcase
  end

  // Pipeline register contents: reset > flush > stall > load.
  always_ff @(posedge clk) begin
    if (!clr) begin
      IR_d    <= 32'd0;
      pc4_d   <= RESET_PC4;
      exc_d   <= 5'd0;
      bd_d    <= 1'b0;
      valid_d <= 1'b0;
    end else if (flush) begin
      IR_d    <= 32'd0;
      pc4_d   <= pc4_f;
      exc_d   <= 5'd0;
      bd_d    <= 1'b0;
      valid_d <= 1'b0;
    end else if (en) begin
      // A faulting fetch is turned into a nop so decode never sees garbage.
      IR_d    <= WAPC_f ? 32'd0 : IFUOUT_f;
      exc_d   <= WAPC_f ? EXC_ADEL : 5'd0;
      pc4_d   <= pc4_f;
      bd_d    <= valid_d & ir_is_branch;
      valid_d <= 1'b1;
    end
  end

  // Saturating count of stall cycles spent holding a real instruction.
  always_ff @(posedge clk) begin
    if (!clr) begin
      stall_cnt <= '0;
    end else if (!flush && !en && valid_d && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Self-checking bench for fd_pipe_reg: directed scenarios plus a randomized
// run against a behavioural model of the IF/ID register.
module tb_fd_pipe_reg;

  logic        clk = 1'b0;
  logic        clr, en, flush, wapc;
  logic [31:0] ifu, pc4f;

  logic [31:0] ir_d, pc4_d, pc_d;
  logic [4:0]  exc_d;
  logic        bd_d, valid_d;
  logic [7:0]  stall_cnt;

  logic [31:0] n_ir, n_pc4, n_pc;
  logic [4:0]  n_exc;
  logic        n_bd, n_valid;
  logic [1:0]  n_cnt;

  int checks = 0;
  int failures = 0;

  // Reference state
  logic [31:0] m_ir, m_pc4;
  logic [4:0]  m_exc;
  logic        m_bd, m_valid;
  int          m_cnt, m_cnt2;

  // Clock
  always #5 clk = ~clk;

  fd_pipe_reg dut (
    .clk(clk), .clr(clr), .en(en), .flush(flush),
    .IFUOUT_f(ifu), .pc4_f(pc4f), .WAPC_f(wapc),
    .IR_d(ir_d), .pc4_d(pc4_d), .pc_d(pc_d), .exc_d(exc_d),
    .bd_d(bd_d), .valid_d(valid_d), .stall_cnt(stall_cnt)
  );

  fd_pipe_reg #(.STALL_CNT_W(2)) dut_narrow (
    .clk(clk), .clr(clr), .en(en), .flush(flush),
    .IFUOUT_f(ifu), .pc4_f(pc4f), .WAPC_f(wapc),
    .IR_d(n_ir), .pc4_d(n_pc4), .pc_d(n_pc), .exc_d(n_exc),
    .bd_d(n_bd), .valid_d(n_valid), .stall_cnt(n_cnt)
  );

  function automatic bit is_branch(input logic [31:0] w);
    logic [5:0] o;
    logic [5:0] f;
    o = w[31:26];
    f = w[5:0];
    if (o inside {6'd4, 6'd5, 6'd6, 6'd7, 6'd1, 6'd2, 6'd3}) return 1'b1;
    if (o == 6'd0 && (f == 6'd8 || f == 6'd9)) return 1'b1;
    return 1'b0;
  endfunction

  // Advance the model by the rules for the current inputs, then clock the DUT.
  task automatic cycle();
    if (!clr) begin
      m_ir = 0; m_pc4 = 32'h3004; m_exc = 0; m_bd = 0; m_valid = 0;
      m_cnt = 0; m_cnt2 = 0;
    end else if (flush) begin
      m_ir = 0; m_pc4 = pc4f; m_exc = 0; m_bd = 0; m_valid = 0;
    end else if (!en) begin
      if (m_valid) begin
        if (m_cnt < 255) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end else begin
      m_bd = m_valid && is_branch(m_ir);
      m_pc4 = pc4f;
      m_valid = 1;
      m_ir = wapc ? 32'd0 : ifu;
      m_exc = wapc ? 5'd4 : 5'd0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [31:0] w, input logic [31:0] p, input logic e);
    clr = 1; en = 1; flush = 0; ifu = w; pc4f = p; wapc = e;
    cycle();
  endtask

  task automatic test_reset();
    clr = 0; en = 1'($urandom); flush = 1'($urandom);
    ifu = $urandom; pc4f = $urandom; wapc = 1'($urandom);
    cycle();
    ifu = $urandom; pc4f = $urandom;
    cycle();
    checks++;
    if (ir_d !== 32'd0 || valid_d !== 1'b0 || pc_d !== 32'h3000 || stall_cnt !== 8'd0
        || exc_d !== 5'd0 || bd_d !== 1'b0) begin
      failures++;
      $display("FAIL reset ir=%h valid=%b pc=%h cnt=%0d exc=%0d bd=%b exp ir=0 valid=0 pc=3000 cnt=0 exc=0 bd=0",
               ir_d, valid_d, pc_d, stall_cnt, exc_d, bd_d);
    end
    load(32'h2408_0005, 32'h3004, 0);
    checks++;
    if (ir_d !== 32'h2408_0005 || pc_d !== 32'h3000 || valid_d !== 1'b1 || exc_d !== 5'd0) begin
      failures++;
      $display("FAIL first_load ir=%h pc=%h valid=%b exc=%0d exp ir=24080005 pc=3000 valid=1 exc=0",
               ir_d, pc_d, valid_d, exc_d);
    end
  endtask

  task automatic test_delay_slot();
    logic [31:0] br[3];
    br[0] = 32'h1109_0003;
    br[1] = 32'h03E0_0008;
    br[2] = 32'h0C00_0C10;
    for (int i = 0; i < 3; i++) begin
      load(br[i], 32'h3008 + 32'(i * 16), 0);
      checks++;
      if (bd_d !== 1'b0) begin
        failures++;
        $display("FAIL bd_branch_itself i=%0d bd=%b exp 0", i, bd_d);
      end
      load(32'h0109_5021, 32'h300C + 32'(i * 16), 0);
      checks++;
      if (bd_d !== 1'b1 || ir_d !== 32'h0109_5021) begin
        failures++;
        $display("FAIL bd_slot i=%0d bd=%b ir=%h exp bd=1 ir=01095021", i, bd_d, ir_d);
      end
      load(32'h0109_5021, 32'h3010 + 32'(i * 16), 0);
      checks++;
      if (bd_d !== 1'b0) begin
        failures++;
        $display("FAIL bd_after_slot i=%0d bd=%b exp 0", i, bd_d);
      end
    end
    // Faulting fetch in a delay slot keeps the BD flag.
    load(32'h1109_0003, 32'h3040, 0);
    load(32'hFFFF_FFFF, 32'h3046, 1);
    checks++;
    if (bd_d !== 1'b1 || exc_d !== 5'd4 || ir_d !== 32'd0) begin
      failures++;
      $display("FAIL bd_adel_slot bd=%b exc=%0d ir=%h exp bd=1 exc=4 ir=0", bd_d, exc_d, ir_d);
    end
  endtask

  task automatic test_addr_error();
    load(32'hFFFF_FFFF, 32'h3002, 1);
    checks++;
    if (ir_d !== 32'd0 || exc_d !== 5'd4 || pc_d !== 32'h2FFE || valid_d !== 1'b1) begin
      failures++;
      $display("FAIL addr_error ir=%h exc=%0d pc=%h valid=%b exp ir=0 exc=4 pc=2ffe valid=1",
               ir_d, exc_d, pc_d, valid_d);
    end
    load(32'h0000_0000, 32'h0000_0000, 0);
    checks++;
    if (pc_d !== 32'hFFFF_FFFC || exc_d !== 5'd0) begin
      failures++;
      $display("FAIL pc_wrap pc=%h exc=%0d exp pc=fffffffc exc=0", pc_d, exc_d);
    end
  endtask

  task automatic test_stall();
    load(32'h1234_5678, 32'h3100, 0);
    for (int i = 1; i <= 8; i++) begin
      clr = 1; en = 0; flush = 0; ifu = $urandom; pc4f = $urandom; wapc = 1'($urandom);
      cycle();
      checks++;
      if (ir_d !== 32'h1234_5678 || pc4_d !== 32'h3100 || valid_d !== 1'b1 || exc_d !== 5'd0
          || bd_d !== 1'b0 || stall_cnt !== 8'(i) || n_cnt !== 2'((i > 3) ? 3 : i)) begin
        failures++;
        $display("FAIL stall i=%0d ir=%h pc4=%h valid=%b cnt=%0d ncnt=%0d exp ir=12345678 pc4=3100 valid=1 cnt=%0d ncnt=%0d",
                 i, ir_d, pc4_d, valid_d, stall_cnt, n_cnt, i, (i > 3) ? 3 : i);
      end
    end
  endtask

  task automatic test_flush_stall();
    clr = 1; en = 0; flush = 1; ifu = 32'h1109_0003; pc4f = 32'h4184; wapc = 0;
    cycle();
    checks++;
    if (valid_d !== 1'b0 || ir_d !== 32'd0 || bd_d !== 1'b0 || pc4_d !== 32'h4184
        || stall_cnt !== 8'd8 || n_cnt !== 2'd3) begin
      failures++;
      $display("FAIL flush_stall valid=%b ir=%h bd=%b pc4=%h cnt=%0d exp valid=0 ir=0 bd=0 pc4=4184 cnt=8",
               valid_d, ir_d, bd_d, pc4_d, stall_cnt);
    end
    // Stalling on a bubble does not count.
    flush = 0;
    cycle();
    checks++;
    if (stall_cnt !== 8'd8 || valid_d !== 1'b0) begin
      failures++;
      $display("FAIL bubble_stall cnt=%0d valid=%b exp cnt=8 valid=0", stall_cnt, valid_d);
    end
  endtask

  task automatic test_reset_mid_stall();
    clr = 0; en = 1; flush = 0;
    cycle();
    load(32'h1109_0003, 32'h3200, 0);
    clr = 1; en = 0;
    cycle();
    cycle();
    checks++;
    if (stall_cnt !== 8'd2) begin
      failures++;
      $display("FAIL pre_reset_cnt cnt=%0d exp 2", stall_cnt);
    end
    clr = 0; en = 0; flush = 1; pc4f = 32'h4444;
    cycle();
    checks++;
    if (ir_d !== 32'd0 || pc4_d !== 32'h3004 || exc_d !== 5'd0 || bd_d !== 1'b0
        || valid_d !== 1'b0 || stall_cnt !== 8'd0 || n_cnt !== 2'd0) begin
      failures++;
      $display("FAIL reset_mid_stall ir=%h pc4=%h exc=%0d bd=%b valid=%b cnt=%0d exp ir=0 pc4=3004 exc=0 bd=0 valid=0 cnt=0",
               ir_d, pc4_d, exc_d, bd_d, valid_d, stall_cnt);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      int r;
      clr   = ($urandom_range(0, 39) != 0);
      flush = ($urandom_range(0, 9) == 0);
      en    = ($urandom_range(0, 3) != 0);
      wapc  = ($urandom_range(0, 7) == 0);
      pc4f  = $urandom;
      r = $urandom_range(0, 9);
      case (r)
        0: ifu = {6'd4, 26'($urandom)};
        1: ifu = {6'd1, 26'($urandom)};
        2: ifu = {6'd3, 26'($urandom)};
        3: ifu = {6'd0, 20'($urandom), 6'd8};
        4: ifu = {6'd0, 20'($urandom), 6'd9};
        5: ifu = {6'd0, 20'($urandom), 6'($urandom_range(10, 63))};
        6: ifu = {6'($urandom_range(2, 7)), 26'($urandom)};
        default: ifu = $urandom;
      endcase
      cycle();
      checks++;
      if (ir_d !== m_ir || pc4_d !== m_pc4 || pc_d !== m_pc4 - 32'd4 || exc_d !== m_exc
          || bd_d !== m_bd || valid_d !== m_valid || stall_cnt !== 8'(m_cnt)
          || n_cnt !== 2'(m_cnt2) || n_bd !== m_bd) begin
        failures++;
        $display("FAIL random c=%0d ir=%h/%h pc4=%h/%h pc=%h exc=%0d/%0d bd=%b/%b valid=%b/%b cnt=%0d/%0d ncnt=%0d/%0d (got/exp)",
                 c, ir_d, m_ir, pc4_d, m_pc4, pc_d, exc_d, m_exc, bd_d, m_bd,
                 valid_d, m_valid, stall_cnt, m_cnt, n_cnt, m_cnt2);
      end
    end
  endtask

  initial begin
    clr = 0; en = 0; flush = 0; ifu = 0; pc4f = 0; wapc = 0;
    m_ir = 0; m_pc4 = 0; m_exc = 0; m_bd = 0; m_valid = 0; m_cnt = 0; m_cnt2 = 0;
    test_reset();
    test_delay_slot();
    test_addr_error();
    test_stall();
    test_flush_stall();
    test_reset_mid_stall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
